// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
// DATA_W of the users must not exceed WB_DATA_MAX; narrower data is zero-extended in the request struct.
package regfile_wb_ctrl_pkg;

   localparam int REG_ADDR_W  = 5;
   localparam int NUM_REGS    = 1 << REG_ADDR_W;
   localparam int WB_DATA_MAX = 64;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic                   valid;
      logic [REG_ADDR_W-1:0]  rd;
      logic [WB_DATA_MAX-1:0] data;
      logic                   is_load;
   } wr_req_t;

   function automatic logic rd_match(input logic                  vld,
                                     input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] rs);
      return vld && (rd == rs);
   endfunction

endpackage

// File: rtl/regfile_wb_ctrl_wb_queue.sv
// Ordered write queue: two enqueues per cycle (slot 0 first), one dequeue, bypass when empty,
// and per-entry destination compares for hazard detection.
module wb_queue
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_In0Valid,
   input  logic [REG_ADDR_W-1:0] i_In0Rd,
   input  logic [DATA_W-1:0]     i_In0Data,
   input  logic                  i_In0IsLoad,
   input  logic                  i_In1Valid,
   input  logic [REG_ADDR_W-1:0] i_In1Rd,
   input  logic [DATA_W-1:0]     i_In1Data,
   input  logic                  i_In1IsLoad,
   input  logic [REG_ADDR_W-1:0] i_QueryRs1,
   input  logic [REG_ADDR_W-1:0] i_QueryRs2,
   output logic                  o_Ready,
   output logic                  o_NextValid,
   output logic [REG_ADDR_W-1:0] o_NextRd,
   output logic [DATA_W-1:0]     o_NextData,
   output logic                  o_NextIsLoad,
   output logic [DEPTH-1:0]      o_Rs1Hit,
   output logic [DEPTH-1:0]      o_Rs2Hit
);

   localparam logic [PTR_W:0] PTR_ONE = 1;

   wr_req_t        mem_q [DEPTH];
   logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
   logic [PTR_W-1:0] wr_idx0, wr_idx1;
   logic           empty, full;
   wr_req_t        in0, in1, first, second, nxt, enq_a, enq_b;
   logic [1:0]     n_enq;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   // With the head leaving this cycle, only a full queue has fewer than two free slots.
   assign o_Ready = !full;
   assign wr_idx0 = wr_ptr_q[PTR_W-1:0];
   assign wr_idx1 = wr_idx0 + PTR_W'(1);

   always_comb begin
      in0    = '{valid: i_In0Valid, rd: i_In0Rd, data: WB_DATA_MAX'(i_In0Data), is_load: i_In0IsLoad};
      in1    = '{valid: i_In1Valid, rd: i_In1Rd, data: WB_DATA_MAX'(i_In1Data), is_load: i_In1IsLoad};
      first  = in0.valid ? in0 : in1;
      second = (in0.valid && in1.valid) ? in1 : '0;
      if (empty) begin
         nxt      = first;
         enq_a    = second;
         enq_b    = '0;
         rd_ptr_d = rd_ptr_q;
      end else begin
         nxt       = mem_q[rd_ptr_q[PTR_W-1:0]];
         nxt.valid = 1'b1;
         enq_a     = first;
         enq_b     = second;
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
      end
      n_enq    = {1'b0, enq_a.valid} + {1'b0, enq_b.valid};
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(n_enq);
   end

   assign o_NextValid  = nxt.valid;
   assign o_NextRd     = nxt.rd;
   assign o_NextData   = nxt.data[DATA_W-1:0];
   assign o_NextIsLoad = nxt.is_load;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (enq_a.valid) mem_q[wr_idx0] <= enq_a;
      if (enq_b.valid) mem_q[wr_idx1] <= enq_b;
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_hit
      logic [PTR_W-1:0] off;
      logic             live;
      assign off         = PTR_W'(g) - rd_ptr_q[PTR_W-1:0];
      assign live        = ({1'b0, off} < count);
      assign o_Rs1Hit[g] = rd_match(live, mem_q[g].rd, i_QueryRs1);
      assign o_Rs2Hit[g] = rd_match(live, mem_q[g].rd, i_QueryRs2);
   end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write port driver: merges ALU and load writes through wb_queue, tracks busy registers.
// Optional WB_STATS_EN builds a saturating counter of not-ready cycles on o_StallCnt.
module regfile_wb_ctrl
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_AluValid,
   input  logic [REG_ADDR_W-1:0] i_AluRd,
   input  logic [DATA_W-1:0]     i_AluData,
   input  logic                  i_LdIssue,
   input  logic [REG_ADDR_W-1:0] i_LdIssueRd,
   input  logic                  i_LdValid,
   input  logic [REG_ADDR_W-1:0] i_LdRd,
   input  logic [DATA_W-1:0]     i_LdData,
   input  logic [REG_ADDR_W-1:0] i_QueryRs1,
   input  logic [REG_ADDR_W-1:0] i_QueryRs2,
   output logic                  o_Ready,
   output logic                  o_Rs1Busy,
   output logic                  o_Rs2Busy,
   output logic                  o_RegWrite,
   output logic [REG_ADDR_W-1:0] o_WriteReg,
   output logic [DATA_W-1:0]     o_WriteData,
   output logic [31:0]           o_StallCnt
);

   logic                  q_ready, ld_acc, alu_acc;
   logic                  nxt_valid, nxt_is_load;
   logic [REG_ADDR_W-1:0] nxt_rd;
   logic [DATA_W-1:0]     nxt_data;
   logic [DEPTH-1:0]      rs1_hit, rs2_hit;
   wr_req_t               wb_q, wb_d;
   logic [NUM_REGS-1:0]   busy_q, busy_d;

   // Writes to x0 vanish here; writes arriving while not ready are a protocol error and dropped.
   assign ld_acc  = i_LdValid  && (i_LdRd  != ZERO_REG) && q_ready;
   assign alu_acc = i_AluValid && (i_AluRd != ZERO_REG) && q_ready;

   wb_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_queue (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_In0Valid   (ld_acc),
      .i_In0Rd      (i_LdRd),
      .i_In0Data    (i_LdData),
      .i_In0IsLoad  (1'b1),
      .i_In1Valid   (alu_acc),
      .i_In1Rd      (i_AluRd),
      .i_In1Data    (i_AluData),
      .i_In1IsLoad  (1'b0),
      .i_QueryRs1   (i_QueryRs1),
      .i_QueryRs2   (i_QueryRs2),
      .o_Ready      (q_ready),
      .o_NextValid  (nxt_valid),
      .o_NextRd     (nxt_rd),
      .o_NextData   (nxt_data),
      .o_NextIsLoad (nxt_is_load),
      .o_Rs1Hit     (rs1_hit),
      .o_Rs2Hit     (rs2_hit)
   );

   always_comb begin
      wb_d         = wb_q;
      wb_d.valid   = 1'b0;
      wb_d.is_load = 1'b0;
      if (nxt_valid) begin
         wb_d.valid   = 1'b1;
         wb_d.rd      = nxt_rd;
         wb_d.data    = WB_DATA_MAX'(nxt_data);
         wb_d.is_load = nxt_is_load;
      end
   end

   // A new load issue to the register retiring this cycle must leave it busy, so set goes last.
   always_comb begin
      busy_d = busy_q;
      if (wb_q.valid && wb_q.is_load) busy_d[wb_q.rd] = 1'b0;
      if (i_LdIssue && (i_LdIssueRd != ZERO_REG)) busy_d[i_LdIssueRd] = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wb_q   <= '0;
         busy_q <= '0;
      end else begin
         wb_q   <= wb_d;
         busy_q <= busy_d;
      end
   end

   assign o_Ready     = q_ready;
   assign o_RegWrite  = wb_q.valid;
   assign o_WriteReg  = wb_q.rd;
   assign o_WriteData = wb_q.data[DATA_W-1:0];

   // The entry on the write port is forwarded by the register file, so only queued/incoming writes count.
   assign o_Rs1Busy = (i_QueryRs1 != ZERO_REG) &&
                      (busy_q[i_QueryRs1] || (|rs1_hit) ||
                       rd_match(ld_acc, i_LdRd, i_QueryRs1) || rd_match(alu_acc, i_AluRd, i_QueryRs1));
   assign o_Rs2Busy = (i_QueryRs2 != ZERO_REG) &&
                      (busy_q[i_QueryRs2] || (|rs2_hit) ||
                       rd_match(ld_acc, i_LdRd, i_QueryRs2) || rd_match(alu_acc, i_AluRd, i_QueryRs2));

`ifdef WB_STATS_EN
   logic [31:0] stall_q;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                           stall_q <= '0;
      else if (!q_ready && stall_q != '1)  stall_q <= stall_q + 32'd1;
   end
   assign o_StallCnt = stall_q;
`else
   assign o_StallCnt = '0;
`endif

   a_no_write_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
      !q_ready |-> !((i_AluValid && i_AluRd != ZERO_REG) || (i_LdValid && i_LdRd != ZERO_REG)));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: expected writes queued at drive time, checked as they retire.
module tb_regfile_wb_ctrl;

   localparam int DATA_W = 64;
   localparam int DEPTH  = 4;

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_AluValid = 1'b0, i_LdIssue = 1'b0, i_LdValid = 1'b0;
   logic [4:0]        i_AluRd = '0, i_LdIssueRd = '0, i_LdRd = '0, i_QueryRs1 = '0, i_QueryRs2 = '0;
   logic [DATA_W-1:0] i_AluData = '0, i_LdData = '0;
   logic              o_Ready, o_Rs1Busy, o_Rs2Busy, o_RegWrite;
   logic [4:0]        o_WriteReg;
   logic [DATA_W-1:0] o_WriteData;
   logic [31:0]       o_StallCnt;

   regfile_wb_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_AluValid(i_AluValid), .i_AluRd(i_AluRd), .i_AluData(i_AluData),
      .i_LdIssue(i_LdIssue), .i_LdIssueRd(i_LdIssueRd),
      .i_LdValid(i_LdValid), .i_LdRd(i_LdRd), .i_LdData(i_LdData),
      .i_QueryRs1(i_QueryRs1), .i_QueryRs2(i_QueryRs2),
      .o_Ready(o_Ready), .o_Rs1Busy(o_Rs1Busy), .o_Rs2Busy(o_Rs2Busy),
      .o_RegWrite(o_RegWrite), .o_WriteReg(o_WriteReg), .o_WriteData(o_WriteData),
      .o_StallCnt(o_StallCnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   stall_exp = 0;

   always @(negedge i_clk) begin
      exp_t e;
      if (!i_rst && o_RegWrite) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_write got rd=%0d data=%h, expected no write", o_WriteReg, o_WriteData);
         end else begin
            e = sb.pop_front();
            if (o_WriteReg !== e.rd || o_WriteData !== e.data) begin
               failures++;
               $display("FAIL sb_write got rd=%0d data=%h, expected rd=%0d data=%h",
                        o_WriteReg, o_WriteData, e.rd, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic [4:0] ard, input logic [DATA_W-1:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [DATA_W-1:0] ld);
      exp_t e;
      i_AluValid = av; i_AluRd = ard; i_AluData = ad;
      i_LdValid  = lv; i_LdRd  = lrd; i_LdData  = ld;
      if (lv && lrd != 5'd0) begin e.rd = lrd; e.data = ld; sb.push_back(e); end
      if (av && ard != 5'd0) begin e.rd = ard; e.data = ad; sb.push_back(e); end
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      idle();
      #12;
      checks++; if (o_RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", o_RegWrite); end
      checks++; if (o_WriteReg !== 5'd0) begin failures++; $display("FAIL reset_writereg got=%0d exp=0", o_WriteReg); end
      checks++; if (o_WriteData !== '0) begin failures++; $display("FAIL reset_writedata got=%h exp=0", o_WriteData); end
      checks++; if (o_Ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_Ready); end
      checks++; if (o_StallCnt !== 32'd0) begin failures++; $display("FAIL reset_stallcnt got=%0d exp=0", o_StallCnt); end
      tick();
      i_rst = 1'b0;
      tick();
   endtask

   task automatic test_single_alu();
      i_QueryRs1 = 5'd5;
      tick(); drive(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, '0);
      @(negedge i_clk);
      checks++; if (o_RegWrite !== 1'b0) begin failures++; $display("FAIL single_n_regwrite got=%b exp=0", o_RegWrite); end
      checks++; if (o_Rs1Busy !== 1'b1) begin failures++; $display("FAIL single_incoming_busy got=%b exp=1", o_Rs1Busy); end
      tick(); idle();
      @(negedge i_clk);
      checks++; if (o_RegWrite !== 1'b1 || o_WriteReg !== 5'd5 || o_WriteData !== 64'h1234) begin
         failures++; $display("FAIL single_n1 got we=%b rd=%0d data=%h exp we=1 rd=5 data=1234", o_RegWrite, o_WriteReg, o_WriteData);
      end
      checks++; if (o_Rs1Busy !== 1'b0) begin failures++; $display("FAIL single_port_not_busy got=%b exp=0", o_Rs1Busy); end
      tick();
      @(negedge i_clk);
      checks++; if (o_RegWrite !== 1'b0) begin failures++; $display("FAIL single_n2_regwrite got=%b exp=0", o_RegWrite); end
      i_QueryRs1 = 5'd0;
   endtask

   task automatic test_dual();
      i_QueryRs2 = 5'd6;
      tick(); drive(1'b1, 5'd6, 64'hA, 1'b1, 5'd7, 64'hB);
      tick(); idle();
      @(negedge i_clk);
      checks++; if (o_RegWrite !== 1'b1 || o_WriteReg !== 5'd7 || o_WriteData !== 64'hB) begin
         failures++; $display("FAIL dual_n1 got we=%b rd=%0d data=%h exp we=1 rd=7 data=b", o_RegWrite, o_WriteReg, o_WriteData);
      end
      checks++; if (o_Rs2Busy !== 1'b1) begin failures++; $display("FAIL dual_queued_busy got=%b exp=1", o_Rs2Busy); end
      tick();
      @(negedge i_clk);
      checks++; if (o_RegWrite !== 1'b1 || o_WriteReg !== 5'd6 || o_WriteData !== 64'hA) begin
         failures++; $display("FAIL dual_n2 got we=%b rd=%0d data=%h exp we=1 rd=6 data=a", o_RegWrite, o_WriteReg, o_WriteData);
      end
      checks++; if (o_Rs2Busy !== 1'b0) begin failures++; $display("FAIL dual_port_not_busy got=%b exp=0", o_Rs2Busy); end
      tick();
      @(negedge i_clk);
      checks++; if (o_RegWrite !== 1'b0) begin failures++; $display("FAIL dual_n3_regwrite got=%b exp=0", o_RegWrite); end
      i_QueryRs2 = 5'd0;
   endtask

   task automatic test_load_busy();
      i_QueryRs1 = 5'd9;
      tick(); i_LdIssue = 1'b1; i_LdIssueRd = 5'd9;
      tick(); i_LdIssue = 1'b0;
      @(negedge i_clk);
      checks++; if (o_Rs1Busy !== 1'b1) begin failures++; $display("FAIL ld_busy_set got=%b exp=1", o_Rs1Busy); end
      tick(); drive(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, '0);
      tick(); idle();
      @(negedge i_clk);
      checks++; if (o_Rs1Busy !== 1'b1) begin failures++; $display("FAIL ld_busy_alu_on_port got=%b exp=1", o_Rs1Busy); end
      tick();
      @(negedge i_clk);
      checks++; if (o_Rs1Busy !== 1'b1) begin failures++; $display("FAIL ld_busy_after_alu got=%b exp=1", o_Rs1Busy); end
      tick(); drive(1'b0, 5'd0, '0, 1'b1, 5'd9, 64'h900);
      tick(); idle();
      @(negedge i_clk);
      checks++; if (o_Rs1Busy !== 1'b1 || o_RegWrite !== 1'b1) begin
         failures++; $display("FAIL ld_busy_on_port got busy=%b we=%b exp busy=1 we=1", o_Rs1Busy, o_RegWrite);
      end
      tick();
      @(negedge i_clk);
      checks++; if (o_Rs1Busy !== 1'b0) begin failures++; $display("FAIL ld_busy_cleared got=%b exp=0", o_Rs1Busy); end
      // a new issue to rd 9 in the same cycle the earlier load retires keeps it busy
      tick(); i_LdIssue = 1'b1; i_LdIssueRd = 5'd9;
      tick(); i_LdIssue = 1'b0; drive(1'b0, 5'd0, '0, 1'b1, 5'd9, 64'h901);
      tick(); idle(); i_LdIssue = 1'b1; i_LdIssueRd = 5'd9;
      tick(); i_LdIssue = 1'b0;
      @(negedge i_clk);
      checks++; if (o_Rs1Busy !== 1'b1) begin failures++; $display("FAIL ld_set_wins got=%b exp=1", o_Rs1Busy); end
      tick(); drive(1'b0, 5'd0, '0, 1'b1, 5'd9, 64'h902);
      tick(); idle();
      tick();
      @(negedge i_clk);
      checks++; if (o_Rs1Busy !== 1'b0) begin failures++; $display("FAIL ld_final_clear got=%b exp=0", o_Rs1Busy); end
      i_QueryRs1 = 5'd0;
   endtask

   task automatic test_rd0();
      i_QueryRs1 = 5'd0; i_QueryRs2 = 5'd0;
      tick(); drive(1'b1, 5'd0, 64'h55, 1'b1, 5'd0, 64'h66); i_LdIssue = 1'b1; i_LdIssueRd = 5'd0;
      @(negedge i_clk);
      checks++; if (o_Rs1Busy !== 1'b0 || o_Rs2Busy !== 1'b0 || o_Ready !== 1'b1) begin
         failures++; $display("FAIL rd0_busy got b1=%b b2=%b rdy=%b exp 0 0 1", o_Rs1Busy, o_Rs2Busy, o_Ready);
      end
      tick(); idle(); i_LdIssue = 1'b0;
      @(negedge i_clk);
      checks++; if (o_RegWrite !== 1'b0) begin failures++; $display("FAIL rd0_no_write got=%b exp=0", o_RegWrite); end
      tick(); drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd0, 64'h77);
      tick(); idle();
      @(negedge i_clk);
      checks++; if (o_RegWrite !== 1'b1 || o_WriteReg !== 5'd3) begin
         failures++; $display("FAIL rd0_bypass got we=%b rd=%0d exp we=1 rd=3", o_RegWrite, o_WriteReg);
      end
      tick();
      @(negedge i_clk);
      checks++; if (o_RegWrite !== 1'b0) begin failures++; $display("FAIL rd0_drained got=%b exp=0", o_RegWrite); end
   endtask

   task automatic test_back_to_back_fill();
      int  cnt = 0;
      int  pairs_left = 6;
      int  n_in;
      int  free_slots;
      logic ready_exp;
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick();
         free_slots = DEPTH - cnt + ((cnt > 0) ? 1 : 0);
         ready_exp  = (free_slots >= 2);
         n_in = (ready_exp && pairs_left > 0) ? 2 : 0;
         if (n_in == 2) begin
            drive(1'b1, 5'(10 + pairs_left), 64'($urandom), 1'b1, 5'(20 + pairs_left), 64'($urandom));
            pairs_left--;
         end else begin
            idle();
         end
         if (!ready_exp) stall_exp++;
         @(negedge i_clk);
         checks++; if (o_Ready !== ready_exp) begin
            failures++; $display("FAIL fill_ready cyc=%0d got=%b exp=%b", cyc, o_Ready, ready_exp);
         end
         cnt = (cnt + n_in > 0) ? cnt + n_in - 1 : 0;
      end
      tick();
      @(negedge i_clk);
`ifdef WB_STATS_EN
      checks++; if (o_StallCnt !== 32'(stall_exp)) begin
         failures++; $display("FAIL fill_stallcnt got=%0d exp=%0d", o_StallCnt, stall_exp);
      end
`else
      checks++; if (o_StallCnt !== 32'd0) begin failures++; $display("FAIL fill_stallcnt_off got=%0d exp=0", o_StallCnt); end
`endif
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL fill_drain got pending=%0d exp=0", sb.size()); end
   endtask

   task automatic test_reset_mid();
      int writes = 0;
      tick(); drive(1'b1, 5'd22, 64'h22, 1'b1, 5'd21, 64'h21); i_LdIssue = 1'b1; i_LdIssueRd = 5'd20;
      tick(); drive(1'b1, 5'd24, 64'h24, 1'b1, 5'd23, 64'h23); i_LdIssue = 1'b0;
      tick(); drive(1'b1, 5'd26, 64'h26, 1'b1, 5'd25, 64'h25);
      tick(); idle();
      i_rst = 1'b1;
      sb.delete();
      stall_exp = 0;
      #1;
      checks++; if (o_RegWrite !== 1'b0 || o_Ready !== 1'b1 || o_WriteReg !== 5'd0) begin
         failures++; $display("FAIL midrst_out got we=%b rdy=%b rd=%0d exp 0 1 0", o_RegWrite, o_Ready, o_WriteReg);
      end
      checks++; if (o_StallCnt !== 32'd0) begin failures++; $display("FAIL midrst_stallcnt got=%0d exp=0", o_StallCnt); end
      for (int rs = 0; rs < 32; rs++) begin
         i_QueryRs1 = 5'(rs); i_QueryRs2 = 5'(rs);
         #1;
         checks++; if (o_Rs1Busy !== 1'b0 || o_Rs2Busy !== 1'b0) begin
            failures++; $display("FAIL midrst_busy rs=%0d got b1=%b b2=%b exp 0 0", rs, o_Rs1Busy, o_Rs2Busy);
         end
      end
      i_QueryRs1 = 5'd0; i_QueryRs2 = 5'd0;
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge i_clk);
         if (o_RegWrite) writes++;
      end
      checks++; if (writes != 0) begin failures++; $display("FAIL midrst_discard got writes=%0d exp=0", writes); end
   endtask

   initial begin
      test_reset();
      test_single_alu();
      test_dual();
      test_load_busy();
      test_rd0();
      test_back_to_back_fill();
      test_reset_mid();
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL final_sb_empty got pending=%0d exp=0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Writer side of the CPU register-file write port (RegWrite / WriteReg / WriteData).
- Merges single-cycle ALU results and variable-latency load responses into a small ordered write queue, then drives one registered write per cycle.
- Keeps a busy scoreboard that decode uses to stall on read-after-write hazards against pending loads and queued writes.

Parameters:
- DATA_W, 64, width of write data.
- DEPTH, 4, write-queue entries; power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), queue pointer width; derived, do not override.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_AluValid  in  1  ALU result valid this cycle.
- i_AluRd  in  5  ALU destination register.
- i_AluData  in  DATA_W  ALU result.
- i_LdIssue  in  1  load issued to memory this cycle.
- i_LdIssueRd  in  5  destination register of the issued load.
- i_LdValid  in  1  load response valid.
- i_LdRd  in  5  load response destination register.
- i_LdData  in  DATA_W  load data.
- i_QueryRs1  in  5  decode source register 1.
- i_QueryRs2  in  5  decode source register 2.
- o_Ready  out  1  queue can accept two writes next cycle.
- o_Rs1Busy  out  1  rs1 has an outstanding write.
- o_Rs2Busy  out  1  rs2 has an outstanding write.
- o_RegWrite  out  1  register-file write enable, registered.
- o_WriteReg  out  5  register-file write address, registered.
- o_WriteData  out  DATA_W  register-file write data, registered.
- o_StallCnt  out  32  count of not-ready cycles; present only with the optional feature.

Behaviour:
- Reset (async, active-high): queue empty, all pointers 0, scoreboard all clear, o_RegWrite=0, o_WriteReg=0, o_WriteData=0, o_Ready=1, o_StallCnt=0. Reset mid-operation discards all queued writes and pending-load busy bits.
- Any write with rd==0 is dropped: not queued, no scoreboard effect.
- Enqueue order in one cycle: load response first, then ALU result. Each queue entry holds {rd, data, is_load}.
- Output stage:
  - Every edge, the output registers load the queue head.
  - If the queue is empty, they load the first incoming write directly (bypass).
  - Otherwise o_RegWrite=0.
  - Latency into an empty queue: 1 cycle. With simultaneous ALU and load writes, the load appears at N+1 and the ALU result at N+2.
- o_Ready=1 when free entries are at least 2, counting the entry dequeued this cycle. Issuing a valid while o_Ready=0 is a protocol violation; the write is dropped, and an assertion flags it in simulation.
- Load responses are never back-pressured. Upstream stops issuing loads when o_Ready=0.
- Scoreboard, 32 busy bits:
  - i_LdIssue with rd!=0 sets busy[rd].
  - A load entry leaving the output stage (o_RegWrite=1 with is_load) clears busy[rd].
  - If set and clear hit the same rd in the same cycle, set wins.
- o_RsXBusy is combinational. It is 1 if busy[rs] is set, or any valid queued entry (excluding the one currently driving o_RegWrite) has rd==rs, or an incoming write this cycle has rd==rs. It is always 0 for rs==0.
- The register file forwards the current-cycle write, so the entry on the write port does not cause busy.
- Write ordering per rd is preserved (FIFO); a later write to the same rd always lands last.
- Pointer wrap: modulo DEPTH, with an extra full/empty bit.

Optional Feature:
- Macro: WB_STATS_EN.
- Defined: o_StallCnt increments each cycle o_Ready=0, saturates at 32'hFFFF_FFFF, and clears on reset.
- Undefined: o_StallCnt tied to 0 and no counter logic is built.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5;
  - a write-request struct {valid, rd, data, is_load};
  - constant ZERO_REG=0.
- Natural sub-module: wb_queue, a dual-enqueue, single-dequeue FIFO with bypass and per-entry rd compare outputs. Scoreboard and output registers stay in the top.

Test Plan:
- Reset asserted mid-stream with 3 entries queued -> o_RegWrite=0, o_Ready=1, o_Rs1Busy=0 for all rs; the queued writes never appear.
- Single ALU write rd=5, data=64'h1234 at cycle N into empty queue -> o_RegWrite=1, o_WriteReg=5, o_WriteData=64'h1234 at N+1 only.
- ALU (rd=6, 0xA) and load response (rd=7, 0xB) in the same cycle -> rd7/0xB at N+1, rd6/0xA at N+2.
- i_LdIssue rd=9, query rs1=9 -> o_Rs1Busy=1 until the cycle after the load write for rd 9 appears on the port; ALU writes to rd 9 do not clear it.
- Writes to rd=0 from both sources -> no o_RegWrite, no busy, queue occupancy unchanged.
- Fill the queue with back-to-back dual writes -> o_Ready drops when free entries <2; with WB_STATS_EN, o_StallCnt equals the number of not-ready cycles.
